// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_pkg
//  Description : Shared constants and types for the pointwise NTT product
//                datapath: Kyber modulus, Montgomery inverse, coefficient
//                type and controller state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package ntt_pkg;

    localparam int KYBER_Q = 3329;
    localparam int QINV    = -3327;   // q^-1 mod 2^16, signed
    localparam int KYBER_N = 256;

    typedef logic signed [15:0] coeff_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/ntt_mul.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_mul
//  Description : Combinational signed Montgomery multiply,
//                r = a*b*2^-16 mod q, result in (-q, q) when |a*b| < q*2^15.
//  Ports       : a, b  - signed 16-bit coefficients
//                r     - signed 16-bit Montgomery product
//  Revision    : 1.0  initial release
// ============================================================================
module ntt_mul
    import ntt_pkg::*;
(
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [15:0] r
);

    localparam logic signed [15:0] c_qinv = 16'(QINV);
    localparam logic signed [31:0] c_q    = 32'(KYBER_Q);

    logic signed [31:0] w_p;
    logic signed [15:0] w_m;
    logic signed [31:0] w_mq;
    logic signed [31:0] w_t;
    logic               w_unused_lo;

    // Full signed product; |a*b| <= 2^30 so 32 bits is exact.
    assign w_p  = 32'(a) * 32'(b);
    // Only the low 16 bits of p*qinv matter, so a 16x16 truncated multiply.
    assign w_m  = w_p[15:0] * c_qinv;
    assign w_mq = 32'(w_m) * c_q;
    // p - m*q is an exact multiple of 2^16; the low half is always zero.
    assign w_t  = w_p - w_mq;
    assign r    = w_t[31:16];

    assign w_unused_lo = ^w_t[15:0];

endmodule
`default_nettype wire

// File: rtl/ntt_pointwise_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_pointwise_ctrl
//  Description : Sequencer for one pointwise Montgomery product of two
//                N-coefficient polynomials through a single ntt_mul.
//                Streams one coefficient per cycle through a 3-stage
//                pipeline: read issue -> multiply/capture -> result write.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                start, abort        - run request / synchronous cancel
//                busy, done          - run in progress / end-of-run pulse
//                rd_en, rd_addr      - shared read port of source RAMs
//                rd_a_data,rd_b_data - source coefficients (1-cycle latency)
//                wr_en, wr_addr,
//                wr_data             - result RAM write port
//  Revision    : 1.0  initial release
// ============================================================================
module ntt_pointwise_ctrl
    import ntt_pkg::*;
#(
    parameter int N  = 256,
    parameter int AW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic signed [15:0]   rd_a_data,
    input  logic signed [15:0]   rd_b_data,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic signed [15:0]   wr_data
);

    // Counter is one bit wider than the address so N-1 never aliases to 0.
    localparam logic [AW:0] c_last = (AW+1)'(N - 1);
    localparam logic [AW:0] c_one  = (AW+1)'(1);

    ctrl_state_e        r_state;
    ctrl_state_e        w_state_nxt;
    logic [AW:0]        r_cnt;
    logic [AW:0]        w_cnt_nxt;
    logic               w_rd_en_nxt;
    logic [AW-1:0]      w_rd_addr_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_kill;

    logic               r_s2_valid;
    logic [AW-1:0]      r_s2_addr;
    logic signed [15:0] w_mul_r;

    assign w_kill = abort && (r_state != IDLE);

    // ------------------------------------------------------------------------
    // Control FSM. All outputs are registered together with the state, so
    // each branch computes the output values for the following cycle. The
    // read for address 0 is issued on the same edge that leaves IDLE/DONE,
    // which is what lets a start in the done cycle chain with no gap.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rd_en_nxt   = 1'b0;
        w_rd_addr_nxt = rd_addr;
        w_busy_nxt    = busy;
        w_done_nxt    = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                if (start && !abort) begin
                    w_state_nxt   = RUN;
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = '0;
                    w_cnt_nxt     = c_one;
                    w_busy_nxt    = 1'b1;
                end else begin
                    w_state_nxt   = IDLE;
                    w_busy_nxt    = 1'b0;
                end
            end

            RUN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = r_cnt[AW-1:0];
                    w_cnt_nxt     = r_cnt + c_one;
                    if (r_cnt == c_last) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (!rd_en && !r_s2_valid) begin
                    // Only the final write is still in flight; it lands on
                    // this edge, so done and busy=0 appear right after it.
                    w_state_nxt = DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            rd_en   <= w_rd_en_nxt;
            rd_addr <= w_rd_addr_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: the address travels alongside the RAM latency so the result
    // is written back to the slot it was read from.
    // ------------------------------------------------------------------------
    ntt_mul u_mul (
        .a (rd_a_data),
        .b (rd_b_data),
        .r (w_mul_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            if (w_kill) begin
                r_s2_valid <= 1'b0;
                wr_en      <= 1'b0;
            end else begin
                r_s2_valid <= rd_en;
                wr_en      <= r_s2_valid;
            end
            r_s2_addr <= rd_addr;
            wr_addr   <= r_s2_addr;
            if (r_s2_valid) begin
                wr_data <= w_mul_r;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ntt_pointwise_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ntt_pointwise_ctrl
//  Description : Self-checking bench for ntt_pointwise_ctrl. Models the two
//                source RAMs and the result RAM, logs every output per cycle
//                and compares runs against cycle/value expectations derived
//                from the Montgomery rule in plain integer arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ntt_pointwise_ctrl;

    localparam int N    = 256;
    localparam int AW   = 8;
    localparam int LOGN = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic signed [15:0] rd_a_data, rd_b_data, wr_data;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always #5 clk = ~clk;

    ntt_pointwise_ctrl #(.N(N), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_a_data (rd_a_data),
        .rd_b_data (rd_b_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    // Memories
    logic signed [15:0] mem_a [N];
    logic signed [15:0] mem_b [N];
    logic signed [15:0] res   [N];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_a_data <= mem_a[rd_addr];
            rd_b_data <= mem_b[rd_addr];
        end
        if (wr_en) begin
            res[wr_addr] <= wr_data;
        end
    end

    // Per-cycle log, sampled mid-cycle
    always @(posedge clk) cyc <= cyc + 1;

    logic               lg_rd_en   [LOGN];
    logic [AW-1:0]      lg_rd_addr [LOGN];
    logic               lg_wr_en   [LOGN];
    logic [AW-1:0]      lg_wr_addr [LOGN];
    logic signed [15:0] lg_wr_data [LOGN];
    logic               lg_busy    [LOGN];
    logic               lg_done    [LOGN];

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            lg_rd_en[cyc]   <= rd_en;
            lg_rd_addr[cyc] <= rd_addr;
            lg_wr_en[cyc]   <= wr_en;
            lg_wr_addr[cyc] <= wr_addr;
            lg_wr_data[cyc] <= wr_data;
            lg_busy[cyc]    <= busy;
            lg_done[cyc]    <= done;
        end
    end

    // Reference: a*b*2^-16 mod q via the signed Montgomery rule
    function automatic int mont(input int a, input int b);
        longint p, m;
        p = longint'(a) * longint'(b);
        m = (p * -3327) & 64'hFFFF;
        if (m >= 32768) m = m - 65536;
        return int'((p - m * 3329) / 65536);
    endfunction

    function automatic logic signed [15:0] rnd_coeff();
        return 16'(int'($urandom_range(0, 6656)) - 3328);
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Issue a one-cycle start in the current cycle; returns its cycle index.
    task automatic pulse_start(output int t);
        start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
    endtask

    // Checks one complete, unaborted run whose start was high in cycle t.
    task automatic check_run(input int t, input string tag);
        int e_rd, e_wr, e_res, e_busy, e_done;
        logic signed [15:0] e;
        e_rd = 0; e_wr = 0; e_res = 0; e_busy = 0; e_done = 0;
        for (int c = t + 1; c <= t + N; c++)
            if (lg_rd_en[c] !== 1'b1 || lg_rd_addr[c] !== AW'(c - t - 1)) e_rd++;
        if (lg_rd_en[t + N + 1] !== 1'b0) e_rd++;
        for (int i = 0; i < N; i++) begin
            e = 16'(mont(int'(mem_a[i]), int'(mem_b[i])));
            if (lg_wr_en[t + 3 + i] !== 1'b1 || lg_wr_addr[t + 3 + i] !== AW'(i) ||
                lg_wr_data[t + 3 + i] !== e) e_wr++;
            if (res[i] !== e) e_res++;
        end
        if (lg_wr_en[t + 2] !== 1'b0 || lg_wr_en[t + N + 3] !== 1'b0) e_wr++;
        for (int c = t + 1; c <= t + N + 2; c++) begin
            if (lg_busy[c] !== 1'b1) e_busy++;
            if (lg_done[c] !== 1'b0) e_done++;
        end
        if (lg_busy[t + N + 3] !== 1'b0) e_busy++;
        check({tag, "_rd_seq_errs"}, e_rd, 0);
        check({tag, "_wr_seq_errs"}, e_wr, 0);
        check({tag, "_result_ram_errs"}, e_res, 0);
        check({tag, "_busy_errs"}, e_busy, 0);
        check({tag, "_early_done_errs"}, e_done, 0);
        check({tag, "_done_at_T+N+3"}, lg_done[t + N + 3], 1);
    endtask

    initial begin
        int t, t2, r, cnt, d0, d1;

        // ---------------- Reset state ----------------
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_addrs_data", {rd_addr, wr_addr, wr_data}, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- Reset mid-RUN at i=100 ----------------
        for (int i = 0; i < N; i++) begin mem_a[i] = rnd_coeff(); mem_b[i] = rnd_coeff(); end
        pulse_start(t);
        wait_until(t + 101);
        check("mid_rd_addr", rd_addr, 100);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outputs",
              {busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data}, 0);
        tick();
        rst_n = 1'b1;
        r = cyc;
        repeat (20) tick();
        cnt = 0;
        for (int c = r; c < r + 20; c++)
            cnt += int'(lg_rd_en[c] === 1'b1) + int'(lg_wr_en[c] === 1'b1) +
                   int'(lg_done[c] === 1'b1) + int'(lg_busy[c] === 1'b1);
        check("post_rst_activity", cnt, 0);

        // ---------------- All ones -> 169 ----------------
        for (int i = 0; i < N; i++) begin mem_a[i] = 16'sd1; mem_b[i] = 16'sd1; end
        pulse_start(t);
        wait_until(t + N + 6);
        check_run(t, "ones");
        check("ones_res0", res[0], 169);
        check("ones_res255", res[N-1], 169);

        // ---------------- a = 2^16 mod q -> identity ----------------
        for (int i = 0; i < N; i++) begin
            mem_a[i] = 16'sd2285;
            mem_b[i] = 16'((i * 3) % 3329);
        end
        mem_a[1] = -16'sd1;  mem_b[1] = 16'sd1;
        mem_a[2] = 16'sd0;   mem_b[2] = 16'sd1234;
        mem_b[3] = 16'sd1000;
        pulse_start(t);
        wait_until(t + N + 6);
        check_run(t, "mont_r");
        check("mont_r_b1000", res[3], 1000);
        check("neg_one", res[1], -169);
        check("zero_a", res[2], 0);
        check("mont_r_b30", res[10], 30);

        // ---------------- Random data, starts during run ignored ----------------
        for (int i = 0; i < N; i++) begin mem_a[i] = rnd_coeff(); mem_b[i] = rnd_coeff(); end
        pulse_start(t);
        wait_until(t + 5);
        start = 1'b1; tick(); start = 1'b0;
        wait_until(t + 200);
        start = 1'b1; tick(); start = 1'b0;
        wait_until(t + N + 8);
        check_run(t, "restart_ignored");
        cnt = 0;
        for (int c = t; c <= t + N + 7; c++) cnt += int'(lg_done[c] === 1'b1);
        check("single_done_pulse", cnt, 1);

        // ---------------- abort / start interplay in IDLE ----------------
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_beats_start_busy", busy, 0);
        check("abort_beats_start_rd_en", rd_en, 0);

        // ---------------- abort at T+50, restart at T+52 ----------------
        for (int i = 0; i < N; i++) begin mem_a[i] = rnd_coeff(); mem_b[i] = rnd_coeff(); end
        pulse_start(t);
        wait_until(t + 50);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_rd_en", rd_en, 0);
        check("abort_wr_en", wr_en, 0);
        check("abort_busy", busy, 0);
        tick();
        pulse_start(t2);
        check("restart_cycle", t2 - t, 52);
        wait_until(t2 + N + 6);
        cnt = 0;
        for (int c = t + 1; c <= t + 51; c++) cnt += int'(lg_wr_en[c] === 1'b1);
        check("abort_write_count", cnt, 48);
        cnt = 0;
        for (int c = t + 1; c <= t2; c++) cnt += int'(lg_done[c] === 1'b1);
        check("abort_no_done", cnt, 0);
        check_run(t2, "after_abort");

        // ---------------- Back-to-back via start in done cycle ----------------
        for (int i = 0; i < N; i++) begin mem_a[i] = rnd_coeff(); mem_b[i] = rnd_coeff(); end
        pulse_start(t);
        wait_until(t + N + 3);
        check("b2b_done_cycle", done, 1);
        pulse_start(t2);
        wait_until(t2 + N + 6);
        check_run(t, "b2b_first");
        check_run(t2, "b2b_second");
        cnt = 0; d0 = -1; d1 = -1;
        for (int c = t; c <= t2 + N + 5; c++) begin
            if (lg_done[c] === 1'b1) begin
                if (cnt == 0) d0 = c; else if (cnt == 1) d1 = c;
                cnt++;
            end
        end
        check("b2b_done_count", cnt, 2);
        check("b2b_done_spacing", d1 - d0, N + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ntt_pointwise_ctrl.md
Name: ntt_pointwise_ctrl

Overview:
Sequencer that runs one full pointwise (coefficient-wise) Montgomery product of two N-coefficient polynomials through a single ntt_mul instance.
- Each run streams coefficient pairs out of a synchronous-read polynomial RAM, multiplies them, and streams results into a result RAM.
- Throughput is one coefficient per cycle, with a fixed 3-stage pipeline.
- Sits between the polynomial-arithmetic top-level FSM (start/done) and the coefficient memories.

Parameters:
N, 256, number of coefficients per polynomial (power of two, >= 4)
AW, 8, address width; AW = log2(N)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a run; honoured only when busy=0
abort  in  1  synchronous cancel; wins over start in the same cycle
busy  out  1  high while a run is in progress
done  out  1  one-cycle pulse when the last result has been written
rd_en  out  1  read strobe to both source RAM ports
rd_addr  out  AW  read address, shared by both source ports
rd_a_data  in  16  signed coefficient a[i], valid the cycle after rd_en
rd_b_data  in  16  signed coefficient b[i], valid the cycle after rd_en
wr_en  out  1  result write strobe
wr_addr  out  AW  result address
wr_data  out  16  signed Montgomery product a[i]*b[i]*2^-16 mod 3329, range (-3329, 3329)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, rd_en, wr_en = 0; rd_addr, wr_addr, wr_data = 0; pipeline valids = 0; counter = 0.
- Reset asserted mid-run discards the run. No done pulse and no further writes after release.
- All outputs are registered.
- States:
  - IDLE: if start and !abort, go to RUN with counter=0.
  - RUN: issue reads while counter <= N-1; after issuing N-1, go to DRAIN.
  - DRAIN: wait for pipeline valids to empty, then go to DONE.
  - DONE: go to IDLE.
- Pipeline, with start sampled at edge T:
  - S1, cycle T+1+i: rd_en=1, rd_addr=i.
  - S2, cycle T+2+i: RAM data presented to ntt_mul (combinational). The ntt_mul output is captured at the end of this cycle, along with the delayed address.
  - S3, cycle T+3+i: wr_en=1, wr_addr=i, wr_data=result.
- Timing for a full run:
  - rd_en high for exactly N consecutive cycles, T+1..T+N; addresses 0..N-1 in order, no gaps.
  - wr_en high for exactly N consecutive cycles, T+3..T+N+2.
  - busy high T+1..T+N+2; done=1 at T+N+3 with busy=0.
  - Start-to-done latency is N+3 cycles.
- start while busy=1 is ignored. start in the done cycle is accepted, so back-to-back runs have no extra gap.
- abort in any non-IDLE state:
  - next cycle: state=IDLE, busy=0, rd_en=0, wr_en=0, pipeline valids cleared, no done pulse.
  - Writes already completed stay in RAM.
- abort in IDLE has no effect.
- Counter wrap: counter is AW+1 bits wide, so N-1 is detected without aliasing to 0.
- Arithmetic (inside ntt_mul, signed 16-bit):
  - p = a*b (32b)
  - m = low16(p*(-3327))
  - out = (p - m*3329) >> 16
- The controller adds no correction; wr_data is exactly the ntt_mul output.
- Inputs satisfying |a*b| < 3329*2^15 give outputs in (-3329, 3329). Wider inputs are passed through unchecked.

Decomposition:
- ntt_pkg holds the shared constants and types:
  - KYBER_Q = 3329, QINV = -3327, KYBER_N = 256;
  - coeff_t (logic signed [15:0]);
  - typedef enum ctrl_state_e {IDLE, RUN, DRAIN, DONE}.
- One sub-module: ntt_mul, instantiated once. The controller never duplicates the reduction logic.

Test Plan:
- Reset mid-RUN at i=100 -> all outputs 0 asynchronously; after release, no wr_en and no done until a new start.
- start with a[i]=1, b[i]=1 for all i, N=256 -> wr_data=169 at wr_addr 0..255, wr_en for 256 consecutive cycles starting T+3, done exactly at T+259.
- a[i]=2285 (2^16 mod q), b[i]=i*3 mod 3329 -> wr_data[i] = b[i] (e.g. b=1000 gives 1000); a=-1, b=1 gives -169; a=0 gives 0.
- start pulsed again at T+5 and T+200 during a run -> ignored: rd_addr sequence unbroken 0..255, single done pulse.
- abort at T+50 -> rd_en/wr_en low from T+51, busy low at T+51, no done. A new start at T+52 runs cleanly to done at T+52+259.
- start asserted in the done cycle -> second run's rd_en begins the next cycle; two done pulses exactly 259 cycles apart.
